// File: rtl/rv_write_lsu.sv
// rv_write_lsu: writeback stage with one registered slot, a valid/ready handshake,
// result select (ALU/MEM/TCM/PC+4/CSR), load alignment/extension and memory timeout.
// Ports: i_clk, i_reset (async, active-high); i_valid/o_ready handshake;
//   captured entry: i_alu_result, i_pc_p4, i_csr_data, i_rd, i_reg_write, i_res_src, i_funct3;
//   load data: i_tcm_rdata, i_mem_rvalid, i_mem_rdata;
//   write port: o_data, o_rd, o_reg_write; status: o_busy, o_bus_err.
// Option RV_WRITE_FWD_EN adds o_fwd_valid/o_fwd_rd/o_fwd_data (last retired write).
module rv_write_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-3:0] i_pc_p4,
    input  logic [XLEN-1:0] i_csr_data,
    input  logic [4:0]      i_rd,
    input  logic            i_reg_write,
    input  logic [2:0]      i_res_src,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_tcm_rdata,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic [XLEN-1:0] o_data,
    output logic [4:0]      o_rd,
    output logic            o_reg_write,
    output logic            o_busy,
    output logic            o_bus_err
`ifdef RV_WRITE_FWD_EN
    ,
    output logic            o_fwd_valid,
    output logic [4:0]      o_fwd_rd,
    output logic [XLEN-1:0] o_fwd_data
`endif
);

    localparam int OFFW = $clog2(XLEN / 8);

    localparam logic [2:0] SRC_ALU = 3'd0;
    localparam logic [2:0] SRC_MEM = 3'd1;
    localparam logic [2:0] SRC_TCM = 3'd2;
    localparam logic [2:0] SRC_PC  = 3'd3;
    localparam logic [2:0] SRC_CSR = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FULL,
        S_WAIT
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t cap_next;

    logic [7:0]      cnt_q;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-3:0] r_pc_p4;
    logic [XLEN-1:0] r_csr_data;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic [2:0]      r_res_src;
    logic [2:0]      r_funct3;

    logic wait_hold;
    logic capture;
    logic retire;
    logic timeout_hit;

    logic [OFFW-1:0] off;
    logic [5:0]      sh_b;
    logic [5:0]      sh_h;
    logic [5:0]      sh_w;
    logic [XLEN-1:0] ld_raw;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     lane_w;
    logic [XLEN-1:0] ld_val;
    logic [XLEN-1:0] result;

    // WAIT without a response is the only condition that stalls upstream.
    assign wait_hold   = (state_q == S_WAIT) && !i_mem_rvalid;
    assign o_ready     = !wait_hold;
    assign capture     = i_valid && o_ready;
    assign retire      = (state_q == S_FULL) ||
                         ((state_q == S_WAIT) && i_mem_rvalid);
    assign timeout_hit = wait_hold && (cnt_q == 8'(TIMEOUT - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        cap_next = S_IDLE;
        if (capture) begin
            cap_next = (i_res_src == SRC_MEM) ? S_WAIT : S_FULL;
        end
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE, S_FULL: state_d = cap_next;
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    state_d = cap_next;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter restarts whenever a fresh entry enters WAIT,
    // including a MEM entry captured in the retire cycle of another.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if ((state_d == S_WAIT) && !wait_hold) begin
            cnt_q <= '0;
        end else if ((state_q == S_WAIT) && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_alu_result <= '0;
            r_pc_p4      <= '0;
            r_csr_data   <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_res_src    <= '0;
            r_funct3     <= '0;
        end else if (capture) begin
            r_alu_result <= i_alu_result;
            r_pc_p4      <= i_pc_p4;
            r_csr_data   <= i_csr_data;
            r_rd         <= i_rd;
            r_reg_write  <= i_reg_write;
            r_res_src    <= i_res_src;
            r_funct3     <= i_funct3;
        end
    end

    // Lane shifts in bits: byte = off*8, half = off[msb:1]*16, word = off[2]*32.
    assign off    = r_alu_result[OFFW-1:0];
    assign sh_b   = 6'(off) << 3;
    assign sh_h   = 6'(off >> 1) << 4;
    assign sh_w   = 6'(off >> 2) << 5;
    assign ld_raw = (r_res_src == SRC_MEM) ? i_mem_rdata : i_tcm_rdata;
    assign lane_b = 8'(ld_raw >> sh_b);
    assign lane_h = 16'(ld_raw >> sh_h);
    assign lane_w = 32'(ld_raw >> sh_w);

    always_comb begin
        ld_val = '0;
        case (r_funct3)
            3'b000: ld_val = XLEN'($signed(lane_b));
            3'b100: ld_val = XLEN'(lane_b);
            3'b001: ld_val = XLEN'($signed(lane_h));
            3'b101: ld_val = XLEN'(lane_h);
            3'b010: ld_val = XLEN'($signed(lane_w));
            3'b110: if (XLEN == 64) ld_val = XLEN'(lane_w);
            3'b011: if (XLEN == 64) ld_val = ld_raw;
            default: ld_val = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (r_res_src)
            SRC_ALU:          result = r_alu_result;
            SRC_MEM, SRC_TCM: result = ld_val;
            SRC_PC:           result = {r_pc_p4, 2'b00};
            SRC_CSR:          result = r_csr_data;
            default:          result = '0;
        endcase
    end

    // Outputs
    always_comb begin
        o_reg_write = 1'b0;
        o_rd        = '0;
        o_data      = '0;
        if (retire) begin
            o_reg_write = r_reg_write && (r_rd != 5'd0);
            o_rd        = r_rd;
            o_data      = result;
        end
    end

    assign o_busy    = (state_q == S_WAIT);
    assign o_bus_err = timeout_hit;

`ifdef RV_WRITE_FWD_EN
    logic            fwd_valid_q;
    logic [4:0]      fwd_rd_q;
    logic [XLEN-1:0] fwd_data_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= '0;
            fwd_data_q  <= '0;
        end else if (retire && r_reg_write && (r_rd != 5'd0)) begin
            fwd_valid_q <= 1'b1;
            fwd_rd_q    <= r_rd;
            fwd_data_q  <= result;
        end
    end

    assign o_fwd_valid = fwd_valid_q;
    assign o_fwd_rd    = fwd_rd_q;
    assign o_fwd_data  = fwd_data_q;
`endif

endmodule
